alarm_sequencer: RTL
====================

# alarm_sequencer

Sequences the operator-facing alarm of the automated irrigation controller. Takes the raw alarm request produced by the alarm-trigger logic (tank at critical level OR error), debounces it, and latches it until acknowledged. Drives a steady buzzer, a blinking lamp and an irrigation-inhibit line. Supports a timed silence period after acknowledge, with automatic re-sounding if the condition persists.

## Interface
- DEBOUNCE_CYCLES, 4: consecutive identical samples required to change the filtered alarm condition; range 1..255.
- BLINK_HALF, 8: lamp half-period in clock cycles while ACTIVE; range 1..255.
- SILENCE_CYCLES, 64: silence window length in clock cycles; range 1..255.
- CNT_W, 8: width of all internal counters; all three parameters must fit in CNT_W bits.

Ports:
- clk_i  in  1  single system clock; all logic on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- alarm_request_i  in  1  raw alarm condition from the alarm-trigger logic; 1 = alarm.
- ack_i  in  1  operator acknowledge, level input; only its rising edge is used.
- buzzer_o  out  1  1 = buzzer on.
- lamp_o  out  1  alarm lamp.
- irrigation_inhibit_o  out  1  1 = irrigation valves must stay closed.
- state_o  out  2  FSM state: 00 IDLE, 01 ACTIVE, 10 SILENCED; 11 is never driven.

## Operation
- Debouncer:
  - alarm_q is the filtered condition.
  - A run counter counts consecutive samples of alarm_request_i that differ from alarm_q.
  - When the count reaches DEBOUNCE_CYCLES, alarm_q takes the new value and the counter clears.
  - Any sample equal to alarm_q clears the counter.
- Ack edge detect:
  - ack_prev is a register of ack_i.
  - ack_rise = ack_i & ~ack_prev, evaluated on the current sample.
- IDLE:
  - Outputs buzzer_o=0, lamp_o=0, irrigation_inhibit_o=0.
  - alarm_q=1 → ACTIVE. ack_rise is ignored.
- ACTIVE (latching):
  - Outputs buzzer_o=1 and irrigation_inhibit_o=1.
  - lamp_o is 1 for the first BLINK_HALF cycles after entry, then toggles every BLINK_HALF cycles. The blink counter restarts on every entry.
  - ack_rise with alarm_q=0 → IDLE.
  - ack_rise with alarm_q=1 → SILENCED.
  - alarm_q falling without ack: stay in ACTIVE. The alarm stays latched until acknowledged.
- SILENCED:
  - Outputs buzzer_o=0, lamp_o=1 steady, irrigation_inhibit_o=1.
  - The silence counter loads 0 on entry and increments each cycle.
  - alarm_q=0 → IDLE. This has priority over everything else.
  - Counter reaches SILENCE_CYCLES-1 with alarm_q=1 → ACTIVE (re-sound).
  - ack_rise → restarts the silence counter at 0 and stays in SILENCED.
- Outputs are decoded from registered state and counters only; there are no combinational paths from inputs to outputs.

## Timing
- Reset (rst_i=1 at an edge) sets:
  - state IDLE, alarm_q=0, ack_prev=0;
  - all counters to 0;
  - buzzer_o=0, lamp_o=0, irrigation_inhibit_o=0, state_o=00.
- Reset mid-operation takes effect at that edge regardless of state.
- Assert latency: alarm_request_i is sampled 1 at edges E1..E_D (D = DEBOUNCE_CYCLES). alarm_q=1 after E_D. State = ACTIVE and buzzer_o=1 after E_{D+1}.
- Deassert latency: symmetric, D edges to clear alarm_q. One more edge to leave SILENCED.
- A glitch shorter than D samples never changes alarm_q.
- Ack: the state changes at the same edge that first samples ack_i=1. Holding ack_i high produces exactly one ack_rise.
- Simultaneous events: the FSM uses the pre-edge alarm_q. In SILENCED, alarm_q=0 beats both expiry and ack_rise.
- If ack_i is held high through reset release, there is an edge at the first cycle after reset; it arrives in IDLE and is ignored.

## Test plan
- Reset: assert rst_i for 2 cycles with alarm_request_i=1. All outputs are 0 and state_o=00. buzzer_o rises exactly 5 edges after rst_i falls (D=4).
- Glitch rejection: pulse alarm_request_i high for 3 cycles, then low. state_o stays 00 and buzzer_o stays 0 throughout.
- Blink and latch:
  - Assert the alarm. lamp_o is 1 for 8 cycles, 0 for 8, 1 for 8.
  - Drop alarm_request_i for 20 cycles. state_o stays 01 and buzzer_o stays 1.
  - Pulse ack_i. The next edge gives state_o=00 and all outputs 0.
- Silence and re-sound:
  - Alarm held, ack pulse gives state_o=10, buzzer_o=0, lamp_o=1.
  - After 64 cycles, state_o=01 and buzzer_o=1.
  - A second ack 30 cycles into the silence window extends it to 64 cycles from that ack.
- Clear during silence: in SILENCED, drop alarm_request_i. state_o=00 after 5 edges, even if the silence counter expires at that same edge.
- Ack held high: hold ack_i=1 for 100 cycles while ACTIVE with the alarm present. Exactly one transition to SILENCED occurs, and the alarm re-sounds at cycle 64.

Source files
------------

// File: rtl/alarm_sequencer.sv
// Operator alarm sequencer for the irrigation controller.
// It debounces the raw alarm request and latches the alarm until the operator
// acknowledges it. It drives the buzzer, a blinking lamp and the irrigation
// inhibit line. After an acknowledge it holds a timed silence window and
// re-sounds the alarm if the condition is still present.
//
//   state       | meaning
//   ------------+---------------------------------------------------------
//   ST_IDLE     | no latched alarm; all outputs off
//   ST_ACTIVE   | alarm latched; buzzer on, lamp blinking, irrigation inhibited
//   ST_SILENCED | acknowledged while still present; buzzer off, lamp steady
module alarm_sequencer #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned BLINK_HALF      = 8,
  parameter int unsigned SILENCE_CYCLES  = 64,
  parameter int unsigned CNT_W           = 8
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       alarm_request_i,
  input  logic       ack_i,
  output logic       buzzer_o,
  output logic       lamp_o,
  output logic       irrigation_inhibit_o,
  output logic [1:0] state_o
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_ACTIVE   = 2'b01,
    ST_SILENCED = 2'b10
  } state_e;

  localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_HALF - 1);
  localparam logic [CNT_W-1:0] SIL_LAST   = CNT_W'(SILENCE_CYCLES - 1);

  state_e           state_q, state_d;
  logic             alarm_q, alarm_d;
  logic [CNT_W-1:0] deb_cnt_q, deb_cnt_d;
  logic             ack_prev_q, ack_prev_d;
  logic [CNT_W-1:0] blink_cnt_q, blink_cnt_d;
  logic             lamp_ph_q, lamp_ph_d;
  logic [CNT_W-1:0] sil_cnt_q, sil_cnt_d;
  logic             ack_rise;

  // Debounce: count consecutive samples that disagree with the filtered value.
  always_comb begin
    alarm_d   = alarm_q;
    deb_cnt_d = '0;
    if (alarm_request_i != alarm_q) begin
      if (deb_cnt_q == DEB_LAST) begin
        alarm_d = alarm_request_i;
      end else begin
        deb_cnt_d = deb_cnt_q + 1'b1;
      end
    end
  end

  assign ack_prev_d = ack_i;
  assign ack_rise   = ack_i & ~ack_prev_q;

  // Next-state logic. Decisions use the pre-edge filtered alarm. In the silence
  // window, a fresh ack wins over expiry at the same edge.
  always_comb begin
    state_d     = state_q;
    blink_cnt_d = blink_cnt_q;
    lamp_ph_d   = lamp_ph_q;
    sil_cnt_d   = sil_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (alarm_q) begin
          state_d     = ST_ACTIVE;
          blink_cnt_d = BLINK_LAST;
          lamp_ph_d   = 1'b1;
        end
      end
      ST_ACTIVE: begin
        if (ack_rise) begin
          state_d   = alarm_q ? ST_SILENCED : ST_IDLE;
          sil_cnt_d = '0;
        end else if (blink_cnt_q == '0) begin
          blink_cnt_d = BLINK_LAST;
          lamp_ph_d   = ~lamp_ph_q;
        end else begin
          blink_cnt_d = blink_cnt_q - 1'b1;
        end
      end
      ST_SILENCED: begin
        if (!alarm_q) begin
          state_d = ST_IDLE;
        end else if (ack_rise) begin
          sil_cnt_d = '0;
        end else if (sil_cnt_q == SIL_LAST) begin
          state_d     = ST_ACTIVE;
          blink_cnt_d = BLINK_LAST;
          lamp_ph_d   = 1'b1;
        end else begin
          sil_cnt_d = sil_cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and counter registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      alarm_q     <= 1'b0;
      deb_cnt_q   <= '0;
      ack_prev_q  <= 1'b0;
      blink_cnt_q <= '0;
      lamp_ph_q   <= 1'b0;
      sil_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      alarm_q     <= alarm_d;
      deb_cnt_q   <= deb_cnt_d;
      ack_prev_q  <= ack_prev_d;
      blink_cnt_q <= blink_cnt_d;
      lamp_ph_q   <= lamp_ph_d;
      sil_cnt_q   <= sil_cnt_d;
    end
  end

  // Outputs are decoded from registered state only.
  always_comb begin
    buzzer_o             = (state_q == ST_ACTIVE);
    irrigation_inhibit_o = (state_q != ST_IDLE);
    lamp_o               = (state_q == ST_ACTIVE) ? lamp_ph_q : (state_q == ST_SILENCED);
    state_o              = state_q;
  end

endmodule
